// File: rtl/crop_pkg.sv
//==============================================================================
// Module  : crop_pkg
// Brief   : Shared types and default dimensions for the crop frame sequencer.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package crop_pkg;

   localparam int c_fp_total = 16;
   localparam int c_in_rows  = 100;
   localparam int c_in_cols  = 160;
   localparam int c_out_rows = 48;
   localparam int c_out_cols = 48;

   typedef logic [c_fp_total-1:0] pixel_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_KICK   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DRAIN  = 2'd3
   } crop_state_t;

endpackage

`default_nettype wire

// File: rtl/axis_reg_slice.sv
//==============================================================================
// Module  : axis_reg_slice
// Brief   : One-entry valid/ready output register; loads while being drained.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module axis_reg_slice #(
   parameter int WIDTH = 16
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic [WIDTH-1:0] i_s_data,
   input  logic             i_s_valid,
   output logic             o_s_ready,
   output logic [WIDTH-1:0] o_m_data,
   output logic             o_m_valid,
   input  logic             i_m_ready
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;

   assign o_s_ready = !r_valid || i_m_ready;
   assign o_m_data  = r_data;
   assign o_m_valid = r_valid;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_s_valid && o_s_ready) begin
         r_data  <= i_s_data;
         r_valid <= 1'b1;
      end else if (i_m_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/crop_frame_sequencer.sv
//==============================================================================
// Module  : crop_frame_sequencer
// Brief   : Forwards a per-frame crop window of a raster frame to the core and
//           sequences the core's ap_start/ap_done block handshake.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module crop_frame_sequencer
   import crop_pkg::*;
#(
   parameter  int FP_TOTAL = c_fp_total,
   parameter  int IN_ROWS  = c_in_rows,
   parameter  int IN_COLS  = c_in_cols,
   parameter  int OUT_ROWS = c_out_rows,
   parameter  int OUT_COLS = c_out_cols,
   localparam int YW       = $clog2(IN_ROWS),
   localparam int XW       = $clog2(IN_COLS)
) (
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   input  logic                start,
   input  logic [YW-1:0]       cfg_y1,
   input  logic [XW-1:0]       cfg_x1,
   output logic                busy,
   output logic                frame_done,
   output logic                cfg_err,
   input  logic [FP_TOTAL-1:0] s_tdata,
   input  logic                s_tvalid,
   output logic                s_tready,
   output logic [FP_TOTAL-1:0] m_tdata,
   output logic                m_tvalid,
   input  logic                m_tready,
   output logic                dut_ap_start,
   input  logic                dut_ap_ready,
   input  logic                dut_ap_done
);

   // One extra bit keeps origin + crop size free of overflow in all compares.
   localparam logic [YW:0]   c_rows_w   = (YW+1)'(IN_ROWS);
   localparam logic [XW:0]   c_cols_w   = (XW+1)'(IN_COLS);
   localparam logic [YW:0]   c_crop_h   = (YW+1)'(OUT_ROWS);
   localparam logic [XW:0]   c_crop_w   = (XW+1)'(OUT_COLS);
   localparam logic [YW-1:0] c_last_row = YW'(IN_ROWS-1);
   localparam logic [XW-1:0] c_last_col = XW'(IN_COLS-1);

   crop_state_t   r_state;
   crop_state_t   w_state_nxt;
   logic [YW-1:0] r_row;
   logic [YW-1:0] r_y1;
   logic [XW-1:0] r_col;
   logic [XW-1:0] r_x1;
   logic          r_done_seen;

   logic w_cfg_bad;
   logic w_accept;
   logic w_in_win;
   logic w_last_px;
   logic w_s_hs;
   logic w_slice_valid;
   logic w_slice_ready;

   assign w_cfg_bad = (({1'b0, cfg_y1} + c_crop_h) > c_rows_w) ||
                      (({1'b0, cfg_x1} + c_crop_w) > c_cols_w);

   assign w_in_win  = (r_row >= r_y1) && ({1'b0, r_row} < ({1'b0, r_y1} + c_crop_h)) &&
                      (r_col >= r_x1) && ({1'b0, r_col} < ({1'b0, r_x1} + c_crop_w));

   assign w_last_px = (r_row == c_last_row) && (r_col == c_last_col);
   assign w_s_hs    = s_tvalid && s_tready;
   assign busy      = (r_state != ST_IDLE);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_accept      = 1'b0;
      cfg_err       = 1'b0;
      frame_done    = 1'b0;
      dut_ap_start  = 1'b0;
      s_tready      = 1'b0;
      w_slice_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (w_cfg_bad) begin
                  cfg_err = 1'b1;
               end else begin
                  w_accept    = 1'b1;
                  w_state_nxt = ST_KICK;
               end
            end
         end
         ST_KICK: begin
            dut_ap_start = 1'b1;
            if (dut_ap_ready) begin
               w_state_nxt = ST_STREAM;
            end
         end
         ST_STREAM: begin
            // Out-of-window pixels are always swallowed so the source never stalls on them.
            s_tready      = w_in_win ? w_slice_ready : 1'b1;
            w_slice_valid = w_in_win && s_tvalid;
            if (w_s_hs && w_last_px) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!m_tvalid && r_done_seen) begin
               frame_done  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_row <= '0;
         r_col <= '0;
         r_y1  <= '0;
         r_x1  <= '0;
      end else if (w_accept) begin
         r_row <= '0;
         r_col <= '0;
         r_y1  <= cfg_y1;
         r_x1  <= cfg_x1;
      end else if ((r_state == ST_STREAM) && w_s_hs && !w_last_px) begin
         if (r_col == c_last_col) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // Sticky so an ap_done arriving before the stream finishes is not lost.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_done_seen <= 1'b0;
      end else if (w_accept) begin
         r_done_seen <= 1'b0;
      end else if ((r_state != ST_IDLE) && dut_ap_done) begin
         r_done_seen <= 1'b1;
      end
   end

   axis_reg_slice #(
      .WIDTH (FP_TOTAL)
   ) u_out_slice (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .i_s_data  (s_tdata),
      .i_s_valid (w_slice_valid),
      .o_s_ready (w_slice_ready),
      .o_m_data  (m_tdata),
      .o_m_valid (m_tvalid),
      .i_m_ready (m_tready)
   );

endmodule

`default_nettype wire

// File: tb/tb_crop_frame_sequencer.sv
//==============================================================================
// Module  : tb_crop_frame_sequencer
// Brief   : Randomized scoreboard bench for crop_frame_sequencer.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_crop_frame_sequencer;
   import crop_pkg::*;

   localparam int YW     = $clog2(c_in_rows);
   localparam int XW     = $clog2(c_in_cols);
   localparam int NPIX   = c_in_rows * c_in_cols;
   localparam int NCROP  = c_out_rows * c_out_cols;

   logic                  ap_clk;
   logic                  ap_rst_n;
   logic                  start;
   logic [YW-1:0]         cfg_y1;
   logic [XW-1:0]         cfg_x1;
   logic                  busy;
   logic                  frame_done;
   logic                  cfg_err;
   logic [c_fp_total-1:0] s_tdata;
   logic                  s_tvalid;
   logic                  s_tready;
   logic [c_fp_total-1:0] m_tdata;
   logic                  m_tvalid;
   logic                  m_tready;
   logic                  dut_ap_start;
   logic                  dut_ap_ready;
   logic                  dut_ap_done;

   crop_frame_sequencer dut (
      .ap_clk       (ap_clk),
      .ap_rst_n     (ap_rst_n),
      .start        (start),
      .cfg_y1       (cfg_y1),
      .cfg_x1       (cfg_x1),
      .busy         (busy),
      .frame_done   (frame_done),
      .cfg_err      (cfg_err),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tready     (s_tready),
      .m_tdata      (m_tdata),
      .m_tvalid     (m_tvalid),
      .m_tready     (m_tready),
      .dut_ap_start (dut_ap_start),
      .dut_ap_ready (dut_ap_ready),
      .dut_ap_done  (dut_ap_done)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   exp_q[$];
   int   out_count, fd_count, fd_cyc, cfg_err_count;
   int   first_out, last_out, last_m_cyc, last_s_cyc, done_cyc;
   int   done_delay = 100;
   bit   rnd_mode   = 1'b0;
   bit   prev_stall = 1'b0;
   logic [c_fp_total-1:0] prev_data;

   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   always @(posedge ap_clk) cyc <= cyc + 1;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every crop handshake, checks stall stability.
   always @(negedge ap_clk) begin
      if (!ap_rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", int'(m_tvalid), 1);
            chk("stall_data", int'(m_tdata), int'(prev_data));
         end
         if (m_tvalid && m_tready) begin
            if (out_count == 0) first_out = int'(m_tdata);
            last_out   = int'(m_tdata);
            last_m_cyc = cyc;
            out_count++;
            if (exp_q.size() == 0) begin
               chk("extra_output", int'(m_tdata), -1);
            end else begin
               chk("m_tdata", int'(m_tdata), exp_q.pop_front());
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
         end
         if (cfg_err) cfg_err_count++;
      end
   end

   // Core model: ready after a random delay, done a programmable time later.
   initial begin
      int phase;
      int cnt;
      phase = 0;
      cnt   = 0;
      dut_ap_ready = 1'b0;
      dut_ap_done  = 1'b0;
      forever begin
         @(posedge ap_clk); #1;
         dut_ap_ready = 1'b0;
         dut_ap_done  = 1'b0;
         if (!ap_rst_n) begin
            phase = 0;
         end else begin
            case (phase)
               0: if (dut_ap_start) begin
                     cnt   = $urandom_range(0, 3);
                     phase = 1;
                  end
               1: if (cnt == 0) begin
                     dut_ap_ready = 1'b1;
                     cnt   = done_delay;
                     phase = 2;
                  end else begin
                     cnt--;
                  end
               default: if (cnt == 0) begin
                     dut_ap_done = 1'b1;
                     done_cyc    = cyc;
                     phase       = 0;
                  end else begin
                     cnt--;
                  end
            endcase
         end
      end
   end

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge ap_clk); #1;
         m_tready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_s_tready"},   int'(s_tready), 0);
      chk({tag, "_m_tvalid"},   int'(m_tvalid), 0);
      chk({tag, "_m_tdata"},    int'(m_tdata), 0);
      chk({tag, "_ap_start"},   int'(dut_ap_start), 0);
      chk({tag, "_busy"},       int'(busy), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_cfg_err"},    int'(cfg_err), 0);
   endtask

   task automatic run_frame(input int y1, input int x1, input bit rnd,
                            input int abort_at, input int ddelay);
      int  idx;
      int  guard;
      int  tmax;
      bit  hs;
      rnd_mode   = rnd;
      done_delay = ddelay;
      exp_q.delete();
      out_count  = 0;
      fd_count   = 0;
      done_cyc   = -1;
      last_m_cyc = -1;
      last_s_cyc = -1;
      for (int r = y1; r < y1 + c_out_rows; r++)
         for (int c = x1; c < x1 + c_out_cols; c++)
            exp_q.push_back(r * c_in_cols + c);

      @(posedge ap_clk); #1;
      cfg_y1 = YW'(y1);
      cfg_x1 = XW'(x1);
      start  = 1'b1;
      @(posedge ap_clk); #1;
      start  = 1'b0;
      chk("ap_start_rise", int'(dut_ap_start), 1);
      chk("busy_on", int'(busy), 1);

      idx   = 0;
      guard = 0;
      while (idx < NPIX && guard < 60000) begin
         if (abort_at >= 0 && idx == abort_at) break;
         s_tvalid = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
         s_tdata  = c_fp_total'(idx);
         @(negedge ap_clk);
         hs = s_tvalid && s_tready;
         if (hs) last_s_cyc = cyc;
         @(posedge ap_clk); #1;
         if (hs) idx++;
         guard++;
      end
      s_tvalid = 1'b0;

      if (abort_at >= 0) begin
         chk("abort_reached", idx, abort_at);
         ap_rst_n = 1'b0;
         #2;
         check_reset_outputs("midrst");
         exp_q.delete();
         repeat (2) @(posedge ap_clk);
         @(negedge ap_clk);
         ap_rst_n = 1'b1;
         return;
      end

      chk("src_handshakes", idx, NPIX);
      guard = 0;
      while (fd_count == 0 && guard < 30000) begin
         @(posedge ap_clk); #1;
         guard++;
      end
      repeat (3) @(posedge ap_clk);
      #1;
      chk("frame_done_count", fd_count, 1);
      chk("out_count", out_count, NCROP);
      chk("queue_empty", exp_q.size(), 0);
      chk("first_out", first_out, y1 * c_in_cols + x1);
      chk("last_out", last_out, (y1 + c_out_rows - 1) * c_in_cols + x1 + c_out_cols - 1);
      tmax = last_m_cyc;
      if (last_s_cyc > tmax) tmax = last_s_cyc;
      if (done_cyc > tmax) tmax = done_cyc;
      chk("done_seen_before_fd", int'(done_cyc >= 0), 1);
      chk("frame_done_cycle", fd_cyc, tmax + 1);
      chk("busy_off", int'(busy), 0);
   endtask

   task automatic reject(input int y1, input int x1);
      int  cerr0;
      bit  seen;
      cerr0 = cfg_err_count;
      seen  = 1'b0;
      @(posedge ap_clk); #1;
      cfg_y1 = YW'(y1);
      cfg_x1 = XW'(x1);
      start  = 1'b1;
      @(negedge ap_clk);
      chk("reject_cfg_err", int'(cfg_err), 1);
      chk("reject_busy", int'(busy), 0);
      @(posedge ap_clk); #1;
      start = 1'b0;
      repeat (5) begin
         @(negedge ap_clk);
         if (dut_ap_start || busy) seen = 1'b1;
      end
      chk("reject_no_start", int'(seen), 0);
      chk("reject_err_pulses", cfg_err_count - cerr0, 1);
   endtask

   initial begin
      ap_rst_n      = 1'b0;
      start         = 1'b0;
      cfg_y1        = '0;
      cfg_x1        = '0;
      s_tdata       = '0;
      s_tvalid      = 1'b0;
      cfg_err_count = 0;
      out_count     = 0;
      fd_count      = 0;
      fd_cyc        = -1;
      first_out     = -1;
      last_out      = -1;
      repeat (3) @(posedge ap_clk);
      #1;
      check_reset_outputs("reset");
      @(negedge ap_clk);
      ap_rst_n = 1'b1;

      run_frame(10, 10, 1'b0, -1, 100);
      run_frame(10, 10, 1'b1, -1, 100);
      reject(53, 0);
      reject(0, 113);
      run_frame(52, 112, 1'b0, -1, 16100);
      run_frame(20, 30, 1'b0, 5000, 100);
      run_frame(0, 0, 1'b0, -1, 300);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
